// File: rtl/aes_block_loader.sv
// ---------------------------------------------------------------------------
// aes_block_loader
//
// Input stage for a combinational AES-128 encryption datapath.
//
// A 32-bit word stream arrives under a valid/ready handshake. It carries
// four key words followed by four plaintext words, most significant word
// first. The loader packs them into two 128-bit registers, then presents
// the pair under a valid/ready handshake. While the pair is presented it
// is held constant, so the downstream combinational rounds always see
// stable operands.
//
// Optional feature (macro KEY_HOLD_EN):
//   When defined, key_reload is sampled on each output handshake.
//     key_reload = 1 : the next block starts with a fresh key.
//     key_reload = 0 : the next block reuses out_key and loads only
//                      the four data words.
//   When undefined, every block reloads the key, and key_reload has no
//   logic attached.
// ---------------------------------------------------------------------------
module aes_block_loader (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         key_reload,
    output logic [127:0] out_word,
    output logic [127:0] out_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   blk_count
);

    typedef enum logic [1:0] {
        ST_LOAD_KEY  = 2'd0,
        ST_LOAD_DATA = 2'd1,
        ST_PRESENT   = 2'd2
    } state_t;

    // Architectural state
    state_t         r_state;
    logic [1:0]     r_wcnt;
    logic [127:0]   r_key;
    logic [127:0]   r_word;
    logic           r_out_valid;
    logic [7:0]     r_blk_count;

    // Next-state / control decode
    state_t         w_state_next;
    logic [1:0]     w_wcnt_next;
    logic           w_key_shift;
    logic           w_word_shift;
    logic           w_valid_next;
    logic           w_blk_inc;
    logic           w_in_ready;
    logic           w_accept_out;
    state_t         w_after_present;

`ifdef KEY_HOLD_EN
    // Key is retained unless the consumer asks for a fresh one.
    assign w_after_present = key_reload ? ST_LOAD_KEY : ST_LOAD_DATA;
`else
    // Every block reloads the key; the reload request is deliberately unused.
    logic w_unused_key_reload;
    assign w_unused_key_reload = key_reload;
    assign w_after_present     = ST_LOAD_KEY;
`endif

    // The output pair is taken when a complete pair is offered and accepted.
    assign w_accept_out = r_out_valid & out_ready;

    // State register and word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD_KEY;
            r_wcnt  <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_wcnt  <= w_wcnt_next;
        end
    end

    // Next-state, word-count and datapath-enable decode.
    always_comb begin
        w_state_next = r_state;
        w_wcnt_next  = r_wcnt;
        w_key_shift  = 1'b0;
        w_word_shift = 1'b0;
        w_valid_next = r_out_valid;
        w_blk_inc    = 1'b0;
        w_in_ready   = 1'b0;

        case (r_state)
            ST_LOAD_KEY: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_key_shift = 1'b1;
                    if (r_wcnt == 2'd3) begin
                        w_wcnt_next  = 2'd0;
                        w_state_next = ST_LOAD_DATA;
                    end else begin
                        w_wcnt_next = r_wcnt + 2'd1;
                    end
                end else begin
                    w_key_shift = 1'b0;
                end
            end

            ST_LOAD_DATA: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_word_shift = 1'b1;
                    if (r_wcnt == 2'd3) begin
                        w_wcnt_next  = 2'd0;
                        w_state_next = ST_PRESENT;
                        w_valid_next = 1'b1;
                    end else begin
                        w_wcnt_next = r_wcnt + 2'd1;
                    end
                end else begin
                    w_word_shift = 1'b0;
                end
            end

            ST_PRESENT: begin
                // No input is accepted here, so a new group can only begin
                // the cycle after the pair has been handed over.
                w_in_ready = 1'b0;
                if (w_accept_out) begin
                    w_valid_next = 1'b0;
                    w_blk_inc    = 1'b1;
                    w_wcnt_next  = 2'd0;
                    w_state_next = w_after_present;
                end else if (!r_out_valid) begin
                    // A present state without a valid pair cannot be left by
                    // a handshake; restart the load rather than lock up.
                    w_wcnt_next  = 2'd0;
                    w_state_next = ST_LOAD_KEY;
                end else begin
                    w_state_next = ST_PRESENT;
                end
            end

            default: begin
                // Unreachable encoding: drop any partial pair and restart.
                w_in_ready   = 1'b0;
                w_wcnt_next  = 2'd0;
                w_valid_next = 1'b0;
                w_state_next = ST_LOAD_KEY;
            end
        endcase
    end

    // Key and plaintext shift registers; held whenever not loading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key  <= 128'd0;
            r_word <= 128'd0;
        end else begin
            if (w_key_shift) begin
                r_key <= {r_key[95:0], in_data};
            end else begin
                r_key <= r_key;
            end
            if (w_word_shift) begin
                r_word <= {r_word[95:0], in_data};
            end else begin
                r_word <= r_word;
            end
        end
    end

    // Output-valid flag and delivered-block counter (wraps modulo 256).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_blk_count <= 8'd0;
        end else begin
            r_out_valid <= w_valid_next;
            if (w_blk_inc) begin
                r_blk_count <= r_blk_count + 8'd1;
            end else begin
                r_blk_count <= r_blk_count;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_word  = r_word;
    assign out_key   = r_key;
    assign out_valid = r_out_valid;
    assign blk_count = r_blk_count;

endmodule

// File: tb/tb_aes_block_loader.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for aes_block_loader.
// Tests the FIPS-197 vector, backpressure, input gaps, reset mid-load,
// key hold (when KEY_HOLD_EN is defined) and block-counter wrap.
// ---------------------------------------------------------------------------
module tb_aes_block_loader;

    logic         clk;
    logic         rst;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         key_reload;
    logic [127:0] out_word;
    logic [127:0] out_key;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   blk_count;

    int n_checks;
    int n_errors;
    logic [7:0] exp_cnt;

    localparam logic [127:0] FIPS_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_WORD = 128'h00112233445566778899aabbccddeeff;

    aes_block_loader u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .key_reload (key_reload),
        .out_word   (out_word),
        .out_key    (out_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .blk_count  (blk_count)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one word once in_ready is seen; returns 1 unit after the
    // accepting edge with in_valid dropped.
    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", {127'd0, in_ready}, 128'd1);
        in_data  = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] k, input logic [127:0] d);
        for (int i = 0; i < 4; i++) send_word(k[127-32*i -: 32]);
        for (int i = 0; i < 4; i++) send_word(d[127-32*i -: 32]);
    endtask

    // Consume the presented pair (out_ready assumed high) and check count.
    task automatic take_block(input string tag);
        @(posedge clk);
        #1;
        exp_cnt = exp_cnt + 8'd1;
        check(tag, {120'd0, blk_count}, {120'd0, exp_cnt});
        check({tag, "_vld0"}, {127'd0, out_valid}, 128'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        exp_cnt    = 8'd0;
        rst        = 1'b1;
        in_data    = 32'd0;
        in_valid   = 1'b0;
        key_reload = 1'b0;
        out_ready  = 1'b1;

        // ---- reset state ----
        @(negedge clk);
        check("rst_valid", {127'd0, out_valid}, 128'd0);
        check("rst_word",  out_word, 128'd0);
        check("rst_key",   out_key,  128'd0);
        check("rst_cnt",   {120'd0, blk_count}, 128'd0);
        check("rst_ready", {127'd0, in_ready}, 128'd1);
        rst = 1'b0;

        // ---- FIPS-197 vector ----
        send_block(FIPS_KEY, FIPS_WORD);
        @(negedge clk);
        check("fips_valid", {127'd0, out_valid}, 128'd1);
        check("fips_key",   out_key,  FIPS_KEY);
        check("fips_word",  out_word, FIPS_WORD);
        check("fips_rdy0",  {127'd0, in_ready}, 128'd0);
        take_block("fips_cnt");

        // ---- backpressure ----
        out_ready = 1'b0;
        send_block(FIPS_KEY, FIPS_WORD);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'hdeadbeef;
            #1;
            check("bp_valid", {127'd0, out_valid}, 128'd1);
            check("bp_rdy",   {127'd0, in_ready}, 128'd0);
            check("bp_key",   out_key,  FIPS_KEY);
            check("bp_word",  out_word, FIPS_WORD);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_cnt = exp_cnt + 8'd1;
        check("bp_cnt", {120'd0, blk_count}, {120'd0, exp_cnt});
        check("bp_rdy1", {127'd0, in_ready}, 128'd1);
        check("bp_key_held", out_key, FIPS_KEY);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_first_key", out_key, 128'h0405060708090a0b0c0d0e0fdeadbeef);
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        for (int i = 0; i < 4; i++) send_word(FIPS_WORD[127-32*i -: 32]);
        @(negedge clk);
        check("bp_new_key", out_key, 128'hdeadbeef111111112222222233333333);
        check("bp_new_vld", {127'd0, out_valid}, 128'd1);
        take_block("bp_new_cnt");

        // ---- input gaps ----
        for (int i = 0; i < 8; i++) begin
            if (i < 4) send_word(FIPS_KEY[127-32*i -: 32]);
            else       send_word(FIPS_WORD[127-32*(i-4) -: 32]);
            if (i < 7) begin
                in_data = 32'hbad0bad0;
                @(posedge clk);
                #1;
                if (i == 6) check("gap_vld_early", {127'd0, out_valid}, 128'd0);
            end
        end
        @(negedge clk);
        check("gap_valid", {127'd0, out_valid}, 128'd1);
        check("gap_key",   out_key,  FIPS_KEY);
        check("gap_word",  out_word, FIPS_WORD);
        take_block("gap_cnt");

        // ---- reset mid-load ----
        send_word(32'h00010203);
        send_word(32'h04050607);
        send_word(32'h08090a0b);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hcafef00d;
        #1;
        check("mrst_key",   out_key,  128'd0);
        check("mrst_word",  out_word, 128'd0);
        check("mrst_cnt",   {120'd0, blk_count}, 128'd0);
        check("mrst_valid", {127'd0, out_valid}, 128'd0);
        check("mrst_ready", {127'd0, in_ready}, 128'd1);
        @(negedge clk);
        check("mrst_nokey", out_key, 128'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_cnt  = 8'd0;
        send_block(FIPS_KEY, FIPS_WORD);
        @(negedge clk);
        check("mrst_fips_key",  out_key,  FIPS_KEY);
        check("mrst_fips_word", out_word, FIPS_WORD);
        check("mrst_fips_vld",  {127'd0, out_valid}, 128'd1);
        take_block("mrst_fips_cnt");

`ifdef KEY_HOLD_EN
        // ---- key hold ----
        send_block(FIPS_KEY, FIPS_WORD);
        key_reload = 1'b0;
        take_block("kh_cnt0");
        for (int i = 0; i < 4; i++) send_word(32'hffffffff);
        @(negedge clk);
        check("kh_valid", {127'd0, out_valid}, 128'd1);
        check("kh_key",   out_key,  FIPS_KEY);
        check("kh_word",  out_word, {128{1'b1}});
        key_reload = 1'b1;
        take_block("kh_cnt1");
        key_reload = 1'b0;
        send_word(32'h01010101);
        send_word(32'h02020202);
        send_word(32'h03030303);
        send_word(32'h04040404);
        check("kh_rl_vld0", {127'd0, out_valid}, 128'd0);
        check("kh_rl_key",  out_key, 128'h01010101020202020303030304040404);
        for (int i = 0; i < 4; i++) send_word(FIPS_WORD[127-32*i -: 32]);
        @(negedge clk);
        check("kh_rl_vld1", {127'd0, out_valid}, 128'd1);
        check("kh_rl_word", out_word, FIPS_WORD);
        take_block("kh_cnt2");
`endif

        // ---- counter wrap ----
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        exp_cnt = 8'd0;
        for (int b = 0; b < 256; b++) begin
            send_block(FIPS_KEY, FIPS_WORD);
            @(posedge clk);
            #1;
            if (b == 254) check("wrap_255", {120'd0, blk_count}, 128'd255);
            if (b == 255) check("wrap_0",   {120'd0, blk_count}, 128'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
